// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and flow controller at the consuming end of ID/EX.
// Resolves load-use stalls, taken branch/jump flushes and HALT drain. It also
// gates pipeline advance for debug single-step and keeps saturating event
// counters for the debug unit.
module hazard_ctrl #(
  parameter int NBITS        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_halt,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_idex_flg_mem_op,
  input  logic             i_idex_flg_mem_type,
  input  logic             i_ex_branch_taken,
  input  logic             i_ex_jump,
  input  logic             i_dbg_mode,
  input  logic             i_dbg_step,
  input  logic             i_dbg_resume,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_halted,
  output logic [NBITS-1:0] o_stall_cnt,
  output logic [NBITS-1:0] o_flush_cnt
);

  // One spare bit so the drain counter can always hold DRAIN_CYCLES.
  localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [NBITS-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             adv, lu_hazard, ctl_hazard;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [NBITS-1:0] sat_inc(input logic [NBITS-1:0] v);
    return (&v) ? v : v + NBITS'(1);
  endfunction

  // A load in ID/EX whose destination feeds the instruction in ID. Register 0
  // is hard-wired, so a load into it never creates a dependency.
  assign lu_hazard = i_idex_flg_mem_op && !i_idex_flg_mem_type &&
                     (i_idex_rt != 5'd0) &&
                     ((i_idex_rt == i_id_rs) ||
                      (i_id_uses_rt && (i_idex_rt == i_id_rt)));

  assign ctl_hazard = i_ex_branch_taken || i_ex_jump;

  // In step mode the pipeline only moves on cycles where step is high.
  assign adv = !i_dbg_mode || i_dbg_step;

  // Next-state and combinational control decode, priority CH > HALT > LU.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (adv) begin
          if (ctl_hazard) begin
            // Load the target and squash both younger stages; any load-use
            // dependency belongs to a squashed instruction.
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            flush_inc     = 1'b1;
          end else if (i_id_halt) begin
            // Let HALT move into EX and freeze the front end behind it.
            drain_d = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end else if (lu_hazard) begin
            // One bubble is enough: the load leaves ID/EX on this edge.
            o_id_ex_flush = 1'b1;
            stall_inc     = 1'b1;
          end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Nothing behind HALT was fetched, so branches here are ignored.
        if (adv) begin
          o_id_ex_flush = 1'b1;
          drain_d       = drain_q - DRAIN_ONE;
          if (drain_q <= DRAIN_ONE) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (i_dbg_resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and drain counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc) begin
        stall_q <= sat_inc(stall_q);
      end
      if (flush_inc) begin
        flush_q <= sat_inc(flush_q);
      end
    end
  end

  assign o_halted    = (state_q == ST_HALTED);
  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int NB   = 4;
  localparam int DC   = 3;
  localparam int MAXV = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, idex_rt;
  logic          id_uses_rt, id_halt, mem_op, mem_type;
  logic          br, jmp, dbg_mode, dbg_step, dbg_resume;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
  logic [NB-1:0] stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: mode 0 = running, 1 = draining, 2 = halted.
  int m_mode  = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.NBITS(NB), .DRAIN_CYCLES(DC)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_id_rs             (id_rs),
    .i_id_rt             (id_rt),
    .i_id_uses_rt        (id_uses_rt),
    .i_id_halt           (id_halt),
    .i_idex_rt           (idex_rt),
    .i_idex_flg_mem_op   (mem_op),
    .i_idex_flg_mem_type (mem_type),
    .i_ex_branch_taken   (br),
    .i_ex_jump           (jmp),
    .i_dbg_mode          (dbg_mode),
    .i_dbg_step          (dbg_step),
    .i_dbg_resume        (dbg_resume),
    .o_pc_write          (pc_write),
    .o_if_id_write       (if_id_write),
    .o_if_id_flush       (if_id_flush),
    .o_id_ex_flush       (id_ex_flush),
    .o_halted            (halted),
    .o_stall_cnt         (stall_cnt),
    .o_flush_cnt         (flush_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_adv();
    return !dbg_mode || dbg_step;
  endfunction

  function automatic bit f_lu();
    int d;
    d = int'(idex_rt);
    return mem_op && !mem_type && d != 0 &&
           (d == int'(id_rs) || (id_uses_rt && d == int'(id_rt)));
  endfunction

  function automatic bit f_ch();
    return br || jmp;
  endfunction

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_flush, halted}.
  function automatic int f_expect();
    if (m_mode == 2) return 5'b00001;
    if (!f_adv())    return 5'b00000;
    if (m_mode == 1) return 5'b00010;
    if (f_ch())      return 5'b11110;
    if (id_halt)     return 5'b00000;
    if (f_lu())      return 5'b00010;
    return 5'b11000;
  endfunction

  // Behavioural model update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_left  <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else if (m_mode == 2) begin
      if (dbg_resume) m_mode <= 0;
    end else if (f_adv()) begin
      if (m_mode == 1) begin
        m_left <= m_left - 1;
        if (m_left - 1 == 0) m_mode <= 2;
      end else if (f_ch()) begin
        m_flush <= (m_flush < MAXV) ? m_flush + 1 : m_flush;
      end else if (id_halt) begin
        m_mode <= 1;
        m_left <= DC;
      end else if (f_lu()) begin
        m_stall <= (m_stall < MAXV) ? m_stall + 1 : m_stall;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ctl", int'({pc_write, if_id_write, if_id_flush, id_ex_flush, halted}), f_expect());
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; idex_rt = 0; id_uses_rt = 0; id_halt = 0;
    mem_op = 0; mem_type = 0; br = 0; jmp = 0;
    dbg_mode = 0; dbg_step = 0; dbg_resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcw", pc_write, 1);
    chk("rst_ifw", if_id_write, 1);
    chk("rst_iff", if_id_flush, 0);
    chk("rst_idf", id_ex_flush, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    rst = 1'b0;
    tick();

    // Load-use on rs.
    mem_op = 1; mem_type = 0; idex_rt = 5; id_rs = 5;
    #1;
    chk("lu_pcw", pc_write, 0);
    chk("lu_ifw", if_id_write, 0);
    chk("lu_idf", id_ex_flush, 1);
    chk("lu_iff", if_id_flush, 0);
    tick();
    idle();
    #1;
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_one_cycle", pc_write, 1);

    // Cases that must not stall.
    mem_op = 1; idex_rt = 0; id_rs = 0;
    #1 chk("lu_r0", pc_write, 1);
    idex_rt = 5; id_rs = 5; mem_type = 1;
    #1 chk("store_nostall", pc_write, 1);
    mem_type = 0; idex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 0;
    #1 chk("no_uses_rt", pc_write, 1);
    chk("no_uses_rt_idf", id_ex_flush, 0);
    tick();
    idle();
    #1 chk("nostall_cnt", stall_cnt, 1);

    // Taken branch wins over a simultaneous load-use.
    mem_op = 1; idex_rt = 5; id_rs = 5; br = 1;
    #1;
    chk("ch_pcw", pc_write, 1);
    chk("ch_ifw", if_id_write, 1);
    chk("ch_iff", if_id_flush, 1);
    chk("ch_idf", id_ex_flush, 1);
    tick();
    idle();
    #1;
    chk("ch_flush_cnt", flush_cnt, 1);
    chk("ch_stall_cnt", stall_cnt, 1);

    // HALT, drain, halted, resume.
    id_halt = 1;
    #1;
    chk("halt_pcw", pc_write, 0);
    chk("halt_idf", id_ex_flush, 0);
    tick();
    id_halt = 0; jmp = 1;
    for (int i = 0; i < DC; i++) begin
      #1;
      chk("drain_pcw", pc_write, 0);
      chk("drain_idf", id_ex_flush, 1);
      chk("drain_halted", halted, 0);
      tick();
    end
    idle();
    #1;
    chk("halted", halted, 1);
    chk("halted_pcw", pc_write, 0);
    chk("halted_idf", id_ex_flush, 0);
    chk("drain_ch_ignored", flush_cnt, 1);
    dbg_resume = 1;
    tick();
    dbg_resume = 0;
    #1;
    chk("resume_halted", halted, 0);
    chk("resume_pcw", pc_write, 1);
    chk("resume_stall", stall_cnt, 1);
    chk("resume_flush", flush_cnt, 1);

    // Step mode.
    dbg_mode = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("step_idle_pcw", pc_write, 0);
      chk("step_idle_ifw", if_id_write, 0);
      tick();
    end
    dbg_step = 1;
    #1 chk("step_pcw", pc_write, 1);
    tick();
    dbg_step = 0;
    #1 chk("step_after_pcw", pc_write, 0);
    tick();

    // Asynchronous reset in the middle of a drain.
    dbg_mode = 0; id_halt = 1;
    tick();
    id_halt = 0;
    #1 chk("pre_rst_drain", id_ex_flush, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_pcw", pc_write, 1);
    chk("arst_ifw", if_id_write, 1);
    chk("arst_idf", id_ex_flush, 0);
    chk("arst_halted", halted, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_flush", flush_cnt, 0);
    tick();
    rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      idex_rt    = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      mem_op     = 1'($urandom_range(0, 1));
      mem_type   = ($urandom_range(0, 3) == 0);
      id_halt    = ($urandom_range(0, 19) == 0);
      br         = ($urandom_range(0, 7) == 0);
      jmp        = ($urandom_range(0, 11) == 0);
      dbg_mode   = ($urandom_range(0, 3) == 0);
      dbg_step   = 1'($urandom_range(0, 1));
      dbg_resume = ($urandom_range(0, 2) == 0);
      tick();
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flow controller that sits at the consuming end of the ID/EX register.
- Reads the ID/EX stage contents (rt, memory flags, branch/jump resolution from EX) and drives the write-enables and flushes back into the PC, IF/ID and ID/EX registers.
- Handles load-use stalls, taken branch/jump flushes and halt-drain.
- Provides a debug single-step gate and saturating event counters for the debug unit.

Parameters:
- NBITS, 32, width of event counters exported to debug unit.
- DRAIN_CYCLES, 3, cycles after a halt in ID before the pipeline is empty (EX, MEM, WB).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_id_rs  in  5  rs field of instruction in ID.
- i_id_rt  in  5  rt field of instruction in ID.
- i_id_uses_rt  in  1  ID instruction reads rt as a source.
- i_id_halt  in  1  ID instruction is HALT.
- i_idex_rt  in  5  rt held in ID/EX (load destination).
- i_idex_flg_mem_op  in  1  ID/EX instruction accesses memory.
- i_idex_flg_mem_type  in  1  0 = load, 1 = store.
- i_ex_branch_taken  in  1  EX resolved a taken branch this cycle.
- i_ex_jump  in  1  EX holds a jump this cycle.
- i_dbg_mode  in  1  1 = step mode, 0 = free run.
- i_dbg_step  in  1  one-cycle pulse, advance one cycle in step mode.
- i_dbg_resume  in  1  leave HALTED, return to RUN.
- o_pc_write  out  1  PC register load enable.
- o_if_id_write  out  1  IF/ID load enable.
- o_if_id_flush  out  1  IF/ID clear to NOP.
- o_id_ex_flush  out  1  ID/EX clear to bubble (all control flags 0).
- o_halted  out  1  pipeline drained and frozen.
- o_stall_cnt  out  NBITS  load-use stalls since reset, saturating.
- o_flush_cnt  out  NBITS  branch/jump flushes since reset, saturating.

Behaviour:
- Reset, asynchronous:
  - state = RUN; drain counter = 0; o_stall_cnt = 0; o_flush_cnt = 0; o_halted = 0.
  - Enable and flush outputs follow the decode below and are therefore 1, 1, 0, 0 in RUN with no hazard.
- States: RUN, DRAIN, HALTED.
- Control outputs are combinational from state and inputs, with no added latency. Counters and state are registered.
- Load-use hazard, LU:
  - i_idex_flg_mem_op = 1 and i_idex_flg_mem_type = 0 and i_idex_rt != 0.
  - And either i_idex_rt == i_id_rs, or (i_id_uses_rt = 1 and i_idex_rt == i_id_rt).
- Control hazard, CH: i_ex_branch_taken or i_ex_jump.
- Advance gate, ADV: 1 when i_dbg_mode = 0; otherwise equal to i_dbg_step. When ADV = 0, pc_write = if_id_write = 0, both flushes = 0 and no state or counter changes.
- RUN with ADV = 1, priority CH > HALT > LU > normal:
  - CH: pc_write = 1 (target load), if_id_write = 1, if_id_flush = 1, id_ex_flush = 1; flush_cnt += 1. LU is ignored because the dependent instruction is squashed.
  - i_id_halt (no CH): pc_write = 0, if_id_write = 0, id_ex_flush = 0 (HALT passes into EX); load drain counter = DRAIN_CYCLES; go to DRAIN.
  - LU: pc_write = 0, if_id_write = 0, id_ex_flush = 1 (one bubble); stall_cnt += 1. The stall lasts exactly 1 cycle because the load leaves ID/EX on the next edge.
  - Else: pc_write = 1, if_id_write = 1, no flushes.
- DRAIN with ADV = 1:
  - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
  - Decrement the drain counter; when it reaches 0, go to HALTED.
  - CH during DRAIN is ignored, because instructions after HALT are never fetched.
- HALTED:
  - All enables 0, flushes 0, o_halted = 1, registered and set on the cycle HALTED is entered.
  - i_dbg_resume goes to RUN, clears o_halted and does not reset the counters.
  - ADV is irrelevant in this state.
- Counters saturate at 2^NBITS-1 and never wrap.
- Reset mid-DRAIN returns immediately to RUN with counters cleared.
- i_dbg_step held high for multiple cycles advances one cycle per high cycle; no edge detection is performed.

Test Plan:
- Load-use: lw with rt = 5 in ID/EX and ID rs = 5 -> exactly one cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1; stall_cnt 0 -> 1. Same case with rt = 0 -> no stall.
- Store plus rt match (mem_type = 1), and lw rt = 7 with ID rt = 7 but i_id_uses_rt = 0 -> no stall in either case.
- Taken branch coinciding with LU -> if_id_flush = 1, id_ex_flush = 1, pc_write = 1; flush_cnt += 1 and stall_cnt unchanged.
- HALT in ID -> DRAIN for 3 cycles with PC frozen, then o_halted = 1. i_dbg_resume -> RUN with o_halted = 0 and counters retained.
- Step mode, i_dbg_mode = 1:
  - No step -> all enables 0 for 10 cycles.
  - One step pulse -> exactly one cycle with pc_write = 1.
- Assert i_rst during DRAIN -> outputs return to RUN values immediately, without waiting for a clock edge, and counters read 0.
